// File: rtl/ram_dma_copy_if.sv
// RAM-side port bundle of ram_dma_copy: address/isReading/dataIn toward the RAM,
// registered dataOut back from it. master = DMA engine, slave = RAM.
interface ram_dma_copy_if #(
  parameter int ADDRESS_SIZE  = 11,
  parameter int MEM_WORD_SIZE = 64
);
  logic [ADDRESS_SIZE-1:0]  ramAddress;
  logic                     ramIsReading;
  logic [MEM_WORD_SIZE-1:0] ramWriteData;
  logic [MEM_WORD_SIZE-1:0] ramReadData;

  modport master (
    output ramAddress, ramIsReading, ramWriteData,
    input  ramReadData
  );

  modport slave (
    input  ramAddress, ramIsReading, ramWriteData,
    output ramReadData
  );
endinterface

// File: rtl/ram_dma_copy.sv
// Block-copy DMA engine owning the single-port RAM while busy (read word, write word, ascending).
// Optional RAM_DMA_FILL_EN adds a one-word-per-cycle fill mode with fillMode/fillData ports.
module ram_dma_copy #(
  parameter int ADDRESS_SIZE  = 11,
  parameter int MEM_WORD_SIZE = 64,
  parameter int COUNT_SIZE    = ADDRESS_SIZE + 1
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     start,
  input  logic [ADDRESS_SIZE-1:0]  srcAddr,
  input  logic [ADDRESS_SIZE-1:0]  dstAddr,
  input  logic [COUNT_SIZE-1:0]    wordCount,
`ifdef RAM_DMA_FILL_EN
  input  logic                     fillMode,
  input  logic [MEM_WORD_SIZE-1:0] fillData,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [COUNT_SIZE-1:0]    wordsDone,
  ram_dma_copy_if.master           ram
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
`ifdef RAM_DMA_FILL_EN
    FILL,
`endif
    DONE
  } state_t;

  state_t                    state, state_next;
  logic [ADDRESS_SIZE-1:0]   src_q, dst_q;
  logic [COUNT_SIZE-1:0]     count_q;
  logic [COUNT_SIZE-1:0]     words_next;
  logic                      write_phase;
  logic [MEM_WORD_SIZE-1:0]  write_data;
`ifdef RAM_DMA_FILL_EN
  logic                      fill_mode_q;
  logic [MEM_WORD_SIZE-1:0]  fill_data_q;
`endif

  assign words_next = wordsDone + COUNT_SIZE'(1);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      count_q   <= '0;
      wordsDone <= '0;
`ifdef RAM_DMA_FILL_EN
      fill_mode_q <= 1'b0;
      fill_data_q <= '0;
`endif
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        src_q     <= srcAddr;
        dst_q     <= dstAddr;
        count_q   <= wordCount;
        wordsDone <= '0;
`ifdef RAM_DMA_FILL_EN
        fill_mode_q <= fillMode;
        fill_data_q <= fillData;
`endif
      end else if (write_phase) begin
        wordsDone <= words_next;
      end
    end
  end

  // Outputs decode from state only, so an async reset forces isReading=1 immediately.
  always_comb begin
    state_next   = state;
    write_phase  = 1'b0;
    write_data   = '0;
    ram.ramAddress   = '0;
    ram.ramIsReading = 1'b1;
    busy = (state != IDLE);
    done = (state == DONE);
    unique case (state)
      IDLE: begin
        if (start) begin
          if (wordCount == '0)
            state_next = DONE;
`ifdef RAM_DMA_FILL_EN
          else if (fillMode)
            state_next = FILL;
`endif
          else
            state_next = READ;
        end
      end
      READ: begin
        ram.ramAddress = src_q + wordsDone[ADDRESS_SIZE-1:0];
        state_next     = WRITE;
      end
      WRITE: begin
        ram.ramAddress   = dst_q + wordsDone[ADDRESS_SIZE-1:0];
        ram.ramIsReading = 1'b0;
        write_data       = ram.ramReadData;
        write_phase      = 1'b1;
        state_next       = (words_next == count_q) ? DONE : READ;
      end
`ifdef RAM_DMA_FILL_EN
      FILL: begin
        ram.ramAddress   = dst_q + wordsDone[ADDRESS_SIZE-1:0];
        ram.ramIsReading = 1'b0;
        write_data       = fill_data_q;
        write_phase      = 1'b1;
        state_next       = (words_next == count_q) ? DONE : FILL;
      end
`endif
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    ram.ramWriteData = write_data;
  end

endmodule

// File: tb/tb_ram_dma_copy.sv
// Self-checking bench for ram_dma_copy: behavioural RAM, reference memory and a write scoreboard.
module tb_ram_dma_copy;
  localparam int AW = 11;
  localparam int DW = 64;
  localparam int CW = AW + 1;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          resetN;
  logic          start;
  logic [AW-1:0] srcAddr, dstAddr;
  logic [CW-1:0] wordCount;
  logic          busy, done;
  logic [CW-1:0] wordsDone;
`ifdef RAM_DMA_FILL_EN
  logic          fillMode;
  logic [DW-1:0] fillData;
`endif

  logic          init_req, pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  wr_t           exp_q[$];
  int            vectors = 0;
  int            miscompares = 0;

  ram_dma_copy_if #(.ADDRESS_SIZE(AW), .MEM_WORD_SIZE(DW)) ram_bus ();

  ram_dma_copy #(.ADDRESS_SIZE(AW), .MEM_WORD_SIZE(DW), .COUNT_SIZE(CW)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .start     (start),
    .srcAddr   (srcAddr),
    .dstAddr   (dstAddr),
    .wordCount (wordCount),
`ifdef RAM_DMA_FILL_EN
    .fillMode  (fillMode),
    .fillData  (fillData),
`endif
    .busy      (busy),
    .done      (done),
    .wordsDone (wordsDone),
    .ram       (ram_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int i);
    return 64'h1111_0000_0000_0000 + 64'(i) * 64'h0001_0003_0005_0007;
  endfunction

  // Single-port RAM: writes when isReading=0, otherwise registers dataOut.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (!ram_bus.ramIsReading) begin
      mem[ram_bus.ramAddress] <= ram_bus.ramWriteData;
    end else begin
      ram_bus.ramReadData <= mem[ram_bus.ramAddress];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write strobe seen on the RAM port must match the head of the scoreboard.
  always @(negedge clk) begin
    if (resetN === 1'b1 && ram_bus.ramIsReading === 1'b0) begin
      wr_t e;
      check("wr_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(ram_bus.ramAddress), 64'(e.addr));
        check("wr_data", ram_bus.ramWriteData, e.data);
      end
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic expect_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.addr = d + AW'(i);
      e.data = ref_mem[s + AW'(i)];
      exp_q.push_back(e);
      ref_mem[e.addr] = e.data;
    end
  endtask

  task automatic check_mem(input string tag);
    int diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check(tag, 64'(diffs), 64'(0));
    check({tag, "_q_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic run_job(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [CW-1:0] c,
                         input int restart_at, input int reset_at, input int exp_lat,
                         input string tag);
    int cyc = 0;
    bit seen = 1'b0;
    @(posedge clk); #1;
    srcAddr = s; dstAddr = d; wordCount = c; start = 1'b1;
    while (!seen && cyc < 600) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (cyc == restart_at) begin
        srcAddr = s + AW'(37); dstAddr = d + AW'(37); wordCount = CW'(1); start = 1'b1;
      end
      @(negedge clk);
      if (cyc == 1) check({tag, "_busy"}, 64'(busy), 64'(1));
      if (cyc == reset_at) begin
        #2 resetN = 1'b0;
        #1;
        check({tag, "_rst_isreading"}, 64'(ram_bus.ramIsReading), 64'(1));
        check({tag, "_rst_busy"}, 64'(busy), 64'(0));
        check({tag, "_rst_wordsdone"}, 64'(wordsDone), 64'(0));
        @(posedge clk); #3;
        resetN = 1'b1;
        return;
      end
      seen = done;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_wordsdone"}, 64'(wordsDone), 64'(c));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'(0));
    check({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    resetN = 1'b0; start = 1'b0; srcAddr = '0; dstAddr = '0; wordCount = '0;
    init_req = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
`ifdef RAM_DMA_FILL_EN
    fillMode = 1'b0; fillData = '0;
`endif
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
    @(posedge clk); #1;
    init_req = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_wordsdone", 64'(wordsDone), 64'(0));
    check("reset_isreading", 64'(ram_bus.ramIsReading), 64'(1));
    check("reset_addr", 64'(ram_bus.ramAddress), 64'(0));
    check("reset_wdata", ram_bus.ramWriteData, 64'(0));
    #2 resetN = 1'b1;

    // Basic copy of four words.
    preload(11'd10, 64'hAAAA_0000_0000_000A);
    preload(11'd11, 64'hBBBB_0000_0000_000B);
    preload(11'd12, 64'hCCCC_0000_0000_000C);
    preload(11'd13, 64'hDDDD_0000_0000_000D);
    expect_copy(11'd10, 11'd100, 4);
    run_job(11'd10, 11'd100, 12'd4, 0, 0, 9, "copy4");
    repeat (3) @(negedge clk);
    check("hold_wordsdone", 64'(wordsDone), 64'(4));
    check_mem("copy4_mem");

    // Zero-length job: done one cycle after start, no writes.
    run_job(11'd5, 11'd6, 12'd0, 0, 0, 1, "count0");
    check_mem("count0_mem");

    // Wrapping source with overlapping destination propagates W,X.
    preload(11'd2046, 64'h5757_0000_0000_0001);
    preload(11'd2047, 64'h5858_0000_0000_0002);
    preload(11'd0,    64'h5959_0000_0000_0003);
    preload(11'd1,    64'h5A5A_0000_0000_0004);
    expect_copy(11'd2046, 11'd0, 4);
    run_job(11'd2046, 11'd0, 12'd4, 0, 0, 9, "wrap");
    check("wrap_mem2", mem[2], 64'h5757_0000_0000_0001);
    check("wrap_mem3", mem[3], 64'h5858_0000_0000_0002);
    check_mem("wrap_mem");

    // Second start during a job is ignored.
    expect_copy(11'd20, 11'd120, 4);
    run_job(11'd20, 11'd120, 12'd4, 3, 0, 9, "restart");
    repeat (4) @(negedge clk);
    check_mem("restart_mem");

    // Reset during the write of word 2 leaves only words 0..1 committed.
    begin
      wr_t e;
      expect_copy(11'd200, 11'd300, 2);
      e.addr = 11'd302;
      e.data = ref_mem[202];
      exp_q.push_back(e);
    end
    run_job(11'd200, 11'd300, 12'd8, 0, 6, 0, "abort");
    repeat (3) @(negedge clk);
    check("abort_idle", 64'(busy), 64'(0));
    check_mem("abort_mem");

`ifdef RAM_DMA_FILL_EN
    fillMode = 1'b1;
    fillData = 64'hDEAD_BEEF_0000_0001;
    for (int i = 0; i < 3; i++) begin
      wr_t e;
      e.addr = 11'd50 + AW'(i);
      e.data = 64'hDEAD_BEEF_0000_0001;
      exp_q.push_back(e);
      ref_mem[e.addr] = e.data;
    end
    run_job(11'd700, 11'd50, 12'd3, 0, 0, 4, "fill");
    fillMode = 1'b0;
    check_mem("fill_mem");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
